// File: rtl/param_ssd_pkg.sv
// param_ssd_pkg: shared types and defaults for the parametrised serial
// sequence detector (param_ssd) and its pattern window sub-module.
// Optional build macro PARITY_CHK_EN enables the PARITY state in param_ssd.
package param_ssd_pkg;

    // Frame FSM states; PARITY is only reachable when PARITY_CHK_EN is defined
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } ssd_state_t;

    // Default configuration: 4-bit start pattern 1110 followed by an 8-bit payload
    localparam int                     DEF_PAT_W       = 4;
    localparam logic [DEF_PAT_W-1:0]   DEF_PATTERN     = 4'b1110;
    localparam int                     DEF_PAYLOAD_LEN = 8;
    localparam int                     DEF_CNT_W       = 8;

    // Payload bit counter must be able to hold the value PAYLOAD_LEN
    function automatic int bit_cnt_width(input int payload_len);
        return $clog2(payload_len + 1);
    endfunction

endpackage

// File: rtl/ssd_pattern_window.sv
// ssd_pattern_window: sliding history window that hunts the serial stream
// for the start pattern. Keeps the last PAT_W-1 accepted bits plus a fill
// counter so that the all-zero reset history can never produce a hit.
// The hit output is Mealy: it combines the stored history with the live bit.
module ssd_pattern_window
    import param_ssd_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic serin,
    output logic hit
);

    // Fill counts up to PAT_W-1, so it needs $clog2(PAT_W) bits (PAT_W >= 2)
    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  history_q;
    logic [PAT_W-2:0]  history_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [PAT_W-1:0]  window;

    // Candidate window is the stored history with the live bit appended as LSB
    always_comb begin
        window = {history_q, serin};
        hit    = shift_en && (fill_q == FILL_MAX) && (window == PATTERN);
    end

    // Slide the window on accepted bits; a hit clears it for the next hunt
    always_comb begin
        history_d = history_q;
        fill_d    = fill_q;
        if (shift_en) begin
            if (hit) begin
                history_d = '0;
                fill_d    = '0;
            end else begin
                history_d = window[PAT_W-2:0];
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    // History and fill registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/param_ssd.sv
// param_ssd: parametrised serial sequence detector and payload collector.
// Hunts for PATTERN on serin (sampled only while detect=1), then collects
// PAYLOAD_LEN bits MSB-first, presents the word on data_out with a one-cycle
// frame_valid pulse and counts completed frames (saturating).
// Optional build macro PARITY_CHK_EN: a trailing even-parity bit follows each
// payload, the frame is delivered after it and parity_err reports a mismatch.
module param_ssd
    import param_ssd_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN     = DEF_PATTERN,
    parameter int               PAYLOAD_LEN = DEF_PAYLOAD_LEN,
    parameter int               CNT_W       = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   serin,
    input  logic                   detect,
    output logic                   collectvalid,
    output logic                   pattern_hit,
    output logic [PAYLOAD_LEN-1:0] data_out,
    output logic                   frame_valid,
    output logic [CNT_W-1:0]       frame_cnt
`ifdef PARITY_CHK_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int                BCNT_W   = bit_cnt_width(PAYLOAD_LEN);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(PAYLOAD_LEN - 1);
    // Index width for addressing one payload bit (at least one bit wide)
    localparam int                IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    ssd_state_t               state_q;
    ssd_state_t               state_d;
    logic [BCNT_W-1:0]        bit_cnt_q;
    logic [BCNT_W-1:0]        bit_cnt_d;
    logic [PAYLOAD_LEN-1:0]   sr_q;
    logic [PAYLOAD_LEN-1:0]   sr_d;
    logic [PAYLOAD_LEN-1:0]   data_q;
    logic [PAYLOAD_LEN-1:0]   data_d;
    logic                     frame_valid_q;
    logic                     frame_valid_d;
    logic [CNT_W-1:0]         frame_cnt_q;
    logic [CNT_W-1:0]         frame_cnt_d;
`ifdef PARITY_CHK_EN
    logic                     parity_err_q;
    logic                     parity_err_d;
`endif

    logic                     hunt_en;
    logic                     last_bit;
    logic [IDX_W-1:0]         slot;
    logic [PAYLOAD_LEN-1:0]   word_now;
    logic [CNT_W-1:0]         cnt_next;

    // Pattern hunting lives in the window; it only sees bits accepted in HUNT
    ssd_pattern_window #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (hunt_en),
        .serin    (serin),
        .hit      (pattern_hit)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: HUNT -> COLLECT on a hit, back after the last payload bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT: begin
                if (pattern_hit) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (detect && last_bit) begin
`ifdef PARITY_CHK_EN
                    state_d = PARITY;
`else
                    state_d = HUNT;
`endif
                end
            end
`ifdef PARITY_CHK_EN
            PARITY: begin
                if (detect) begin
                    state_d = HUNT;
                end
            end
`endif
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // FSM outputs and decodes: Mealy collect strobe and window enable
    always_comb begin
        hunt_en      = detect && (state_q == HUNT);
        collectvalid = detect && (state_q == COLLECT);
        last_bit     = (bit_cnt_q == LAST_BIT);
    end

    // Payload assembly, frame delivery and saturating frame count
    always_comb begin
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        data_d        = data_q;
        frame_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
`ifdef PARITY_CHK_EN
        parity_err_d  = parity_err_q;
`endif

        // Bit k of the payload lands at position PAYLOAD_LEN-1-k, which is the
        // same word an MSB-first shift register would hold after the last bit
        slot             = IDX_W'(LAST_BIT - bit_cnt_q);
        word_now         = sr_q;
        word_now[slot]   = serin;
        cnt_next         = (frame_cnt_q == {CNT_W{1'b1}}) ? frame_cnt_q : frame_cnt_q + 1'b1;

        if (pattern_hit) begin
            bit_cnt_d = '0;
        end

        if (collectvalid) begin
            sr_d = word_now;
            if (last_bit) begin
                bit_cnt_d = '0;
`ifndef PARITY_CHK_EN
                data_d        = word_now;
                frame_valid_d = 1'b1;
                frame_cnt_d   = cnt_next;
`endif
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

`ifdef PARITY_CHK_EN
        // Parity bit: deliver the held payload and flag odd overall parity
        if (detect && (state_q == PARITY)) begin
            data_d        = sr_q;
            parity_err_d  = (^sr_q) ^ serin;
            frame_valid_d = 1'b1;
            frame_cnt_d   = cnt_next;
        end
`endif
    end

    // Datapath registers; reset discards any partial frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
`ifdef PARITY_CHK_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            data_q        <= data_d;
            frame_valid_q <= frame_valid_d;
            frame_cnt_q   <= frame_cnt_d;
`ifdef PARITY_CHK_EN
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign data_out    = data_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
`ifdef PARITY_CHK_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_param_ssd.sv
// tb_param_ssd: table-driven directed bench for param_ssd (default 1110 +
// 8-bit payload configuration) plus hand-written multi-cycle sequences.
// A second instance with CNT_W=2 shares the stimulus to show saturation.
// Works in both builds; rows and frame lengths follow PARITY_CHK_EN.
module tb_param_ssd;

    logic       clk = 1'b0;
    logic       rst;
    logic       serin;
    logic       detect;
    logic       collectvalid;
    logic       pattern_hit;
    logic [7:0] data_out;
    logic       frame_valid;
    logic [7:0] frame_cnt;
    logic       sat_collectvalid;
    logic       sat_pattern_hit;
    logic [7:0] sat_data_out;
    logic       sat_frame_valid;
    logic [1:0] sat_frame_cnt;
`ifdef PARITY_CHK_EN
    logic       parity_err;
    logic       sat_parity_err;
    localparam int FRAME_BITS = 13;
`else
    localparam int FRAME_BITS = 12;
`endif

    typedef struct {
        logic       det;
        logic       sin;
        logic       hit;
        logic       cv;
        logic       fv;
        logic [7:0] data;
        logic [7:0] cnt;
        logic       perr;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // 100 MHz-style clock, inputs change on the falling edge
    always #5 clk = ~clk;

    param_ssd #(
        .PAT_W       (4),
        .PATTERN     (4'b1110),
        .PAYLOAD_LEN (8),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .serin        (serin),
        .detect       (detect),
        .collectvalid (collectvalid),
        .pattern_hit  (pattern_hit),
        .data_out     (data_out),
        .frame_valid  (frame_valid),
        .frame_cnt    (frame_cnt)
`ifdef PARITY_CHK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    param_ssd #(
        .PAT_W       (4),
        .PATTERN     (4'b1110),
        .PAYLOAD_LEN (8),
        .CNT_W       (2)
    ) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .serin        (serin),
        .detect       (detect),
        .collectvalid (sat_collectvalid),
        .pattern_hit  (sat_pattern_hit),
        .data_out     (sat_data_out),
        .frame_valid  (sat_frame_valid),
        .frame_cnt    (sat_frame_cnt)
`ifdef PARITY_CHK_EN
        ,
        .parity_err   (sat_parity_err)
`endif
    );

    // Single comparison with failure report
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bit slot on the falling edge, then settle before sampling
    task automatic applyStimulus(input logic det, input logic sin);
        @(negedge clk);
        detect = det;
        serin  = sin;
        #1;
    endtask

    // Compare all outputs against one table row
    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("row%0d hit", idx),  32'(pattern_hit),  32'(v.hit));
        check($sformatf("row%0d cv", idx),   32'(collectvalid), 32'(v.cv));
        check($sformatf("row%0d fv", idx),   32'(frame_valid),  32'(v.fv));
        check($sformatf("row%0d data", idx), 32'(data_out),     32'(v.data));
        check($sformatf("row%0d cnt", idx),  32'(frame_cnt),    32'(v.cnt));
`ifdef PARITY_CHK_EN
        if (v.fv) begin
            check($sformatf("row%0d perr", idx), 32'(parity_err), 32'(v.perr));
        end
`endif
    endtask

    function automatic void add_row(input logic det, input logic sin, input logic hit,
                                    input logic cv, input logic fv, input logic [7:0] data,
                                    input logic [7:0] cnt, input logic perr);
        vec_t v;
        v.det  = det;  v.sin = sin; v.hit  = hit; v.cv  = cv;
        v.fv   = fv;   v.data = data; v.cnt = cnt; v.perr = perr;
        vecs.push_back(v);
    endfunction

    // Pattern 1110 with the hit expected on the final 0
    function automatic void add_pattern(input logic [7:0] data, input logic [7:0] cnt);
        add_row(1, 1, 0, 0, 0, data, cnt, 0);
        add_row(1, 1, 0, 0, 0, data, cnt, 0);
        add_row(1, 1, 0, 0, 0, data, cnt, 0);
        add_row(1, 0, 1, 0, 0, data, cnt, 0);
    endfunction

    // Eight payload bits MSB first, collectvalid high on each
    function automatic void add_payload(input logic [7:0] w, input logic [7:0] data,
                                        input logic [7:0] cnt);
        for (int i = 7; i >= 0; i--) begin
            add_row(1, w[i], 0, 1, 0, data, cnt, 0);
        end
    endfunction

    // Full frame with detect=1 throughout (parity bit appended when enabled)
    task automatic send_frame(input logic [7:0] w);
        logic [3:0] pat;
        pat = 4'b1110;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, pat[i]);
        for (int i = 7; i >= 0; i--) applyStimulus(1'b1, w[i]);
`ifdef PARITY_CHK_EN
        applyStimulus(1'b1, ^w);
`endif
    endtask

    initial begin
        logic [12:0] fb;
        logic [7:0]  words [5];
        logic [7:0]  w;
        logic [3:0]  pat;
        int          cyc;
        int          fv_cycles[$];

        rst    = 1'b1;
        detect = 1'b0;
        serin  = 1'b0;

`ifdef PARITY_CHK_EN
        // Frame B2 with correct parity 0, then back-to-back B2 with wrong parity 1
        add_pattern(8'h00, 8'd0);
        add_payload(8'hB2, 8'h00, 8'd0);
        add_row(1, 0, 0, 0, 0, 8'h00, 8'd0, 0);
        add_row(1, 1, 0, 0, 1, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 0, 1, 0, 0, 8'hB2, 8'd1, 0);
        add_payload(8'hB2, 8'hB2, 8'd1);
        add_row(1, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(0, 0, 0, 0, 1, 8'hB2, 8'd2, 1);
        add_row(0, 0, 0, 0, 0, 8'hB2, 8'd2, 1);
`else
        // Basic frame 1110 + B2
        add_pattern(8'h00, 8'd0);
        add_payload(8'hB2, 8'h00, 8'd0);
        add_row(0, 0, 0, 0, 1, 8'hB2, 8'd1, 0);
        // Same frame with detect gaps mid-pattern (3) and mid-payload (2)
        add_row(1, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(0, 0, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(0, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(0, 0, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 0, 1, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(1, 0, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(1, 0, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(0, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(0, 1, 0, 0, 0, 8'hB2, 8'd1, 0);
        add_row(1, 0, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(1, 1, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(1, 0, 0, 1, 0, 8'hB2, 8'd1, 0);
        add_row(0, 0, 0, 0, 1, 8'hB2, 8'd2, 0);
        // False start 111110 then all-ones payload: single hit, none in payload
        for (int i = 0; i < 5; i++) add_row(1, 1, 0, 0, 0, 8'hB2, 8'd2, 0);
        add_row(1, 0, 1, 0, 0, 8'hB2, 8'd2, 0);
        add_payload(8'hFF, 8'hB2, 8'd2);
        add_row(0, 0, 0, 0, 1, 8'hFF, 8'd3, 0);
        add_row(0, 0, 0, 0, 0, 8'hFF, 8'd3, 0);
`endif

        // Reset state while rst is held, even with detect=1
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        check("reset hit",  32'(pattern_hit),  32'd0);
        check("reset cv",   32'(collectvalid), 32'd0);
        check("reset fv",   32'(frame_valid),  32'd0);
        check("reset data", 32'(data_out),     32'd0);
        check("reset cnt",  32'(frame_cnt),    32'd0);
        detect = 1'b0;
        rst    = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].det, vecs[i].sin);
            checkOutput(vecs[i], i);
        end

        // Reset in the middle of a payload discards the frame immediately
        pat = 4'b1110;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, pat[i]);
        w = 8'hB2;
        for (int i = 7; i >= 3; i--) applyStimulus(1'b1, w[i]);
        applyStimulus(1'b1, 1'b1);
        check("midrst cv before", 32'(collectvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst cv",   32'(collectvalid), 32'd0);
        check("midrst data", 32'(data_out),     32'd0);
        check("midrst cnt",  32'(frame_cnt),    32'd0);
        check("midrst fv",   32'(frame_valid),  32'd0);
        detect = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'h5A);
        applyStimulus(1'b0, 1'b0);
        check("postrst data", 32'(data_out),    32'h5A);
        check("postrst fv",   32'(frame_valid), 32'd1);
        check("postrst cnt",  32'(frame_cnt),   32'd1);
`ifdef PARITY_CHK_EN
        check("postrst perr", 32'(parity_err),  32'd0);
`endif

        // Back-to-back frames with no idle bits, five in a row
        rst    = 1'b1;
        detect = 1'b0;
        #1;
        check("b2b reset cnt", 32'(sat_frame_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        words[0] = 8'hB2; words[1] = 8'h3C; words[2] = 8'h81;
        words[3] = 8'h7E; words[4] = 8'h55;
        cyc = 0;
        for (int f = 0; f < 5; f++) begin
            w = words[f];
`ifdef PARITY_CHK_EN
            fb = {4'b1110, w, ^w};
`else
            fb = {1'b0, 4'b1110, w};
`endif
            for (int b = 0; b < FRAME_BITS; b++) begin
                applyStimulus(1'b1, fb[FRAME_BITS-1-b]);
                cyc++;
                if (frame_valid) fv_cycles.push_back(cyc);
                if (b == 3) check($sformatf("b2b hit f%0d", f), 32'(pattern_hit), 32'd1);
                if (f == 2 && b == 0) begin
                    check("b2b fv after 2", 32'(frame_valid), 32'd1);
                    check("b2b cnt after 2", 32'(frame_cnt), 32'd2);
                    check("b2b data after 2", 32'(data_out), 32'h3C);
                end
            end
        end
        applyStimulus(1'b0, 1'b0);
        cyc++;
        if (frame_valid) fv_cycles.push_back(cyc);
        check("b2b fv pulses", 32'(fv_cycles.size()), 32'd5);
        check("b2b fv spacing",
              (fv_cycles.size() >= 2) ? 32'(fv_cycles[1] - fv_cycles[0]) : 32'd0,
              32'(FRAME_BITS));
        check("b2b final data", 32'(data_out),      32'h55);
        check("b2b final cnt",  32'(frame_cnt),     32'd5);
        check("b2b sat cnt",    32'(sat_frame_cnt), 32'd3);
        applyStimulus(1'b0, 1'b0);
        check("b2b fv drop",    32'(frame_valid),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_ssd.md
Name: param_ssd

Overview:
- Parametrised serial sequence detector and collector; next generation of the fixed Mealy SSD.
- Hunts a serial bit stream for a configurable start pattern. Then collects a configurable-length payload, with a Mealy collect-valid strobe, and presents the assembled word.
- Sits between the serial line front end and the word-level consumer. It counts completed frames.

Parameters:
- PAT_W, 4: start pattern length in bits; must be at least 2.
- PATTERN, 4'b1110: start pattern, MSB is the first bit received.
- PAYLOAD_LEN, 8: payload bits per frame; must be at least 1.
- CNT_W, 8: width of the frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- serin  in  1  serial data bit.
- detect  in  1  bit-enable; serin is sampled only when detect=1.
- collectvalid  out  1  Mealy; high while the current serin is a payload bit.
- pattern_hit  out  1  Mealy; high in the cycle the last pattern bit is on serin.
- data_out  out  PAYLOAD_LEN  last completed payload; first received bit is the MSB.
- frame_valid  out  1  registered one-cycle pulse when data_out updates.
- frame_cnt  out  CNT_W  completed frames; saturates at all-ones.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=HUNT, history=0, fill=0, payload shift register=0, bit counter=0. Outputs: data_out=0, frame_valid=0, frame_cnt=0. collectvalid and pattern_hit are 0 while rst=1.
- detect=0: no state, history, counter or shift-register change. collectvalid=0, pattern_hit=0. frame_valid still deasserts after its single cycle.
- States: HUNT and COLLECT; with PARITY_CHK_EN, also PARITY.
- HUNT:
  - On each edge with detect=1, history <= {history[PAT_W-2:0], serin}. fill increments and saturates at PAT_W-1.
  - pattern_hit = detect & (fill==PAT_W-1) & ({history[PAT_W-2:0], serin}==PATTERN).
  - fill prevents false hits on reset zeros.
  - Overlapping candidates within HUNT are matched naturally by the sliding window.
  - On hit: next state COLLECT, bit counter=0, history=0, fill=0.
- COLLECT:
  - collectvalid = detect.
  - On each edge with detect=1: shift register <= {sr[PAYLOAD_LEN-2:0], serin}, counter++.
  - When counter==PAYLOAD_LEN-1 and detect=1, that bit completes the frame:
    - data_out <= completed word (shifted value including serin);
    - frame_valid=1 on the next cycle;
    - frame_cnt++ unless saturated;
    - next state HUNT.
  - Payload bits never feed the pattern history. A pattern straddling the end of a payload is not detected.
- Back-to-back frames: the first pattern bit may arrive in the cycle immediately after the last payload bit.
- Latency: data_out and frame_valid are valid one clock after the edge that samples the last payload bit.
- Reset mid-COLLECT: the partial frame is discarded and data_out returns to 0.
- Widths: counter is $clog2(PAYLOAD_LEN+1) bits. Pattern compare is exactly PAT_W bits.

Optional Feature:
- Macro: PARITY_CHK_EN.
- Defined:
  - After the last payload bit, state goes to PARITY instead of HUNT.
  - The next detect=1 bit is an even-parity bit over the payload. collectvalid=0 for it.
  - frame_valid, the data_out update and frame_cnt++ occur one cycle after the parity bit is sampled.
  - Extra output parity_err (1 bit, reset 0): registered, coincident with frame_valid. It is 1 when the XOR of payload and parity bit is 1.
  - The frame is delivered even on a parity error.
  - PARITY returns to HUNT.
- Undefined: no PARITY state and no parity_err port; the frame completes on the last payload bit.

Decomposition:
- Package param_ssd_pkg holds:
  - state enum (HUNT, COLLECT, PARITY);
  - default constants for PAT_W, PATTERN and PAYLOAD_LEN;
  - a function computing counter width.
- One natural sub-module, ssd_pattern_window: history shift register, fill counter and Mealy match compare, with pattern parameters.
- FSM, payload shifter and frame counter stay in param_ssd.

Test Plan:
- Frame: detect=1; serin 1,1,1,0, then payload 1,0,1,1,0,0,1,0.
  - pattern_hit high on the 4th bit.
  - collectvalid high for 8 cycles.
  - Next cycle: data_out=8'hB2, frame_valid pulse, frame_cnt=1.
- Gaps: same stream with detect=0 for 3 cycles mid-pattern and 2 cycles mid-payload.
  - Identical data_out=8'hB2.
  - collectvalid=0 during the gaps.
- False start: serin 1,1,1,1,1,0 then payload 8'hFF.
  - Single hit on the 0.
  - data_out=8'hFF; no hit during the all-ones payload.
- Reset mid-frame: assert rst after 5 payload bits.
  - Immediate collectvalid=0; data_out=0, frame_cnt=0.
  - A fresh full frame afterwards gives a correct word and frame_cnt=1.
- Back-to-back: two frames with no idle bits.
  - Two frame_valid pulses 12 cycles apart; frame_cnt=2.
  - With CNT_W=2 and 5 frames, frame_cnt stays at 3.
- PARITY_CHK_EN: frame 8'hB2 followed by parity bit 0, then 8'hB2 followed by 1.
  - First frame: parity_err=0.
  - Second frame: parity_err=1.
  - frame_valid lands one cycle after each parity bit.
